regfile_write_arbiter: RTL

Write-side front end and read bypass for the r2w1 register file. It merges a never-stalling core write-back port and a back-pressured external (host/inter-core) write port onto the single register-file write port. After reset it clears every register to zero. It also forwards in-flight writes onto both read outputs, so the core always sees the newest value.

---
 rtl/regfile_write_arbiter_pkg.sv | 15 +
 rtl/regfile_ext_fifo.sv | 52 +++++
 rtl/regfile_write_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter and its FIFO.
// Holds the clear-FSM state encoding and the occupancy pointer width rule.
package regfile_write_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // The extra MSB tells full from empty when the index bits are equal.
    function automatic int ptr_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/regfile_ext_fifo.sv
// Synchronous FIFO for external write requests ({addr, data}).
// The head is read combinationally. The FIFO accepts a push while full if it pops in the same cycle.
module regfile_ext_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW    = ptr_width(DEPTH_BITS);
    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign wr_ptr_d = wr_ptr_q + PW'(do_push);
    assign rd_ptr_d = rd_ptr_q + PW'(do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges core write-back and buffered external writes onto one register-file write port.
// It clears the file after reset and forwards in-flight writes to both read ports.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int    DATA_WIDTH     = 16,
    parameter int    ADDR_WIDTH     = 4,
    parameter int    EXT_DEPTH_BITS = 2,
    parameter string RAM_TYPE       = "auto"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_data,
    input  logic                  ext_valid,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_data,
    output logic                  ext_ready,
    output logic                  init_busy,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rf_data_a,
    input  logic [DATA_WIDTH-1:0] rf_data_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output arb_state_e            dbg_state
);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

    arb_state_e                       state_q;
    logic [ADDR_WIDTH-1:0]            clr_cnt_q;
    logic                             rf_we_q;
    logic [ADDR_WIDTH-1:0]            rf_addr_q;
    logic [DATA_WIDTH-1:0]            rf_data_q;
    logic                             hit_a_q, hit_a_d, hit_b_q, hit_b_d;
    logic [DATA_WIDTH-1:0]            hold_a_q, hold_a_d, hold_b_q, hold_b_d;

    logic                             win_we;
    logic [ADDR_WIDTH-1:0]            win_addr;
    logic [DATA_WIDTH-1:0]            win_data;
    logic                             fifo_pop, fifo_push, fifo_full, fifo_empty;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_rdata;

    // Handshake: an external request transfers on a cycle where ext_valid && ext_ready.
    // ext_ready depends only on registered state, never on ext_valid.
    assign ext_ready = (state_q == ST_RUN) && !fifo_full;
    assign fifo_push = ext_valid && ext_ready;
    assign init_busy = (state_q == ST_INIT);
    assign dbg_state = state_q;

    regfile_ext_fifo #(
        .WIDTH      (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH_BITS (EXT_DEPTH_BITS)
    ) u_ext_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({ext_addr, ext_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        win_we   = 1'b0;
        win_addr = core_addr;
        win_data = core_data;
        fifo_pop = 1'b0;
        if (state_q == ST_INIT) begin
            win_we   = 1'b1;
            win_addr = clr_cnt_q;
            win_data = '0;
        end else if (core_we) begin
            win_we = 1'b1;
        end else if (!fifo_empty) begin
            win_we   = 1'b1;
            fifo_pop = 1'b1;
            win_addr = fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
            win_data = fifo_rdata[DATA_WIDTH-1:0];
        end
    end

    // The winner this cycle is newer than the write already sitting in the rf stage.
    always_comb begin
        hit_a_d  = 1'b1;
        hold_a_d = win_data;
        if (!(win_we && win_addr == rd_addr_a)) begin
            hold_a_d = rf_data_q;
            hit_a_d  = rf_we_q && (rf_addr_q == rd_addr_a);
        end
        hit_b_d  = 1'b1;
        hold_b_d = win_data;
        if (!(win_we && win_addr == rd_addr_b)) begin
            hold_b_d = rf_data_q;
            hit_b_d  = rf_we_q && (rf_addr_q == rd_addr_b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            hit_a_q   <= 1'b0;
            hit_b_q   <= 1'b0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
        end else begin
            rf_we_q  <= win_we;
            hit_a_q  <= hit_a_d;
            hit_b_q  <= hit_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            if (win_we) begin
                rf_addr_q <= win_addr;
                rf_data_q <= win_data;
            end
            if (state_q == ST_INIT) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr_w = rf_addr_q;
    assign rf_data_w = rf_data_q;
    assign data_a    = hit_a_q ? hold_a_q : rf_data_a;
    assign data_b    = hit_b_q ? hold_b_q : rf_data_b;

endmodule
